pipe_ctrl: RTL and testbench

Pipelined control unit for the five-stage RISC-V core: decodes the ID-stage instruction into control fields and carries them through the EX, MEM and WB pipeline registers. Handles bubbles, branch flush and multi-cycle multiply stalls, and generates the stall to PC and IF/ID. It replaces the purely combinational decoder plus the separate per-stage control latches.

---
 rtl/pipe_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: decodes the ID instruction and carries control through EX/MEM/WB.
// Define CTRL_LOAD_USE_EN to enable load-use hazard detection and stall.
module pipe_ctrl #(
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned REG_W   = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        instr_i,
    input  logic               flush_i,
    output logic [ALUOP_W-1:0] ex_alu_op_o,
    output logic               ex_alu_src_o,
    output logic               ex_branch_o,
    output logic [REG_W-1:0]   ex_rd_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [REG_W-1:0]   mem_rd_o,
    output logic               wb_reg_write_o,
    output logic               wb_mem_to_reg_o,
    output logic [REG_W-1:0]   wb_rd_o,
    output logic               stall_o
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_MUL = ALUOP_W'(3);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [ALUOP_W-1:0] w_alu_op;
    logic               w_alu_src;
    logic               w_branch;
    logic               w_mem_read;
    logic               w_mem_write;
    logic               w_reg_write;
    logic               w_mem_to_reg;
    logic [REG_W-1:0]   w_rd;
    logic               w_is_mul;

    logic               w_load_use;
    logic               w_mul_enter;
    logic               w_busy;
    logic               w_busy_last;
    logic               w_unused;

    logic [ALUOP_W-1:0] r_ex_alu_op;
    logic               r_ex_alu_src;
    logic               r_ex_branch;
    logic               r_ex_mem_read;
    logic               r_ex_mem_write;
    logic               r_ex_reg_write;
    logic               r_ex_mem_to_reg;
    logic [REG_W-1:0]   r_ex_rd;

    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_mem_reg_write;
    logic               r_mem_mem_to_reg;
    logic [REG_W-1:0]   r_mem_rd;

    logic               r_wb_reg_write;
    logic               r_wb_mem_to_reg;
    logic [REG_W-1:0]   r_wb_rd;

    // Opcode decode of the ID-stage instruction; unknown opcodes decode as a bubble
    always_comb begin
        w_alu_op     = ALU_ADD;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_rd         = '0;
        w_is_mul     = 1'b0;
        case (instr_i[6:0])
            OPC_R: begin
                w_reg_write = 1'b1;
                w_rd        = REG_W'(instr_i[11:7]);
                if (instr_i[30]) begin
                    w_alu_op = ALU_SUB;
                end else if (instr_i[25]) begin
                    w_alu_op = ALU_MUL;
                    w_is_mul = 1'b1;
                end else begin
                    w_alu_op = ALUOP_W'(instr_i[14:12]);
                end
            end
            OPC_I: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_rd        = REG_W'(instr_i[11:7]);
                w_alu_op    = ALUOP_W'(instr_i[14:12]);
            end
            OPC_LOAD: begin
                w_alu_src    = 1'b1;
                w_reg_write  = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_rd         = REG_W'(instr_i[11:7]);
            end
            OPC_STORE: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                w_branch = 1'b1;
                w_alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign w_unused = ^instr_i;

`ifdef CTRL_LOAD_USE_EN
    logic w_uses_rs2;
    assign w_uses_rs2 = (instr_i[6:0] == OPC_R) || (instr_i[6:0] == OPC_STORE) ||
                        (instr_i[6:0] == OPC_BRANCH);
    assign w_load_use = r_ex_mem_read && (r_ex_rd != '0) &&
                        ((r_ex_rd == REG_W'(instr_i[19:15])) ||
                         (w_uses_rs2 && (r_ex_rd == REG_W'(instr_i[24:20]))));
`else
    assign w_load_use = 1'b0;
`endif

    assign w_mul_enter = w_is_mul && !w_load_use && !flush_i;

    // MUL FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // MUL FSM next state; the final BUSY edge (counter at 1) releases EX
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_mul_enter && (MUL_LAT > 1)) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // MUL FSM outputs
    always_comb begin
        w_busy      = 1'b0;
        w_busy_last = 1'b0;
        case (r_state)
            S_BUSY: begin
                w_busy      = 1'b1;
                w_busy_last = (r_cnt == CNT_ONE);
            end
            default: ;
        endcase
    end

    assign stall_o = w_busy || w_load_use;

    // EX register: holds during MUL, bubbles on load-use, flush and MUL release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ex_alu_op     <= '0;
            r_ex_alu_src    <= 1'b0;
            r_ex_branch     <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
            r_ex_rd         <= '0;
        end else if (w_busy && !w_busy_last) begin
            r_ex_alu_op     <= r_ex_alu_op;
        end else if (w_busy_last || w_load_use || flush_i) begin
            r_ex_alu_op     <= '0;
            r_ex_alu_src    <= 1'b0;
            r_ex_branch     <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
            r_ex_rd         <= '0;
        end else begin
            r_ex_alu_op     <= w_alu_op;
            r_ex_alu_src    <= w_alu_src;
            r_ex_branch     <= w_branch;
            r_ex_mem_read   <= w_mem_read;
            r_ex_mem_write  <= w_mem_write;
            r_ex_reg_write  <= w_reg_write;
            r_ex_mem_to_reg <= w_mem_to_reg;
            r_ex_rd         <= w_rd;
        end
    end

    // MEM register: bubble while a MUL is still occupying EX
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_rd         <= '0;
        end else if (w_busy && !w_busy_last) begin
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_rd         <= '0;
        end else begin
            r_mem_read       <= r_ex_mem_read;
            r_mem_write      <= r_ex_mem_write;
            r_mem_reg_write  <= r_ex_reg_write;
            r_mem_mem_to_reg <= r_ex_mem_to_reg;
            r_mem_rd         <= r_ex_rd;
        end
    end

    // WB register always advances
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
            r_wb_rd         <= '0;
        end else begin
            r_wb_reg_write  <= r_mem_reg_write;
            r_wb_mem_to_reg <= r_mem_mem_to_reg;
            r_wb_rd         <= r_mem_rd;
        end
    end

    assign ex_alu_op_o     = r_ex_alu_op;
    assign ex_alu_src_o    = r_ex_alu_src;
    assign ex_branch_o     = r_ex_branch;
    assign ex_rd_o         = r_ex_rd;
    assign mem_read_o      = r_mem_read;
    assign mem_write_o     = r_mem_write;
    assign mem_rd_o        = r_mem_rd;
    assign wb_reg_write_o  = r_wb_reg_write;
    assign wb_mem_to_reg_o = r_wb_mem_to_reg;
    assign wb_rd_o         = r_wb_rd;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random instruction
// streams compared against a stage-level reference model.
module tb_pipe_ctrl;

    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned REG_W   = 5;
`ifdef CTRL_LOAD_USE_EN
    localparam bit LU_EN = 1'b1;
`else
    localparam bit LU_EN = 1'b0;
`endif

    localparam logic [31:0] I_ADD3  = 32'h002081B3;
    localparam logic [31:0] I_MUL5  = 32'h027302B3;
    localparam logic [31:0] I_BEQ   = 32'h00000063;
    localparam logic [31:0] I_SUB4  = 32'h40420233;
    localparam logic [31:0] I_LW8   = 32'h0000A403;
    localparam logic [31:0] I_ADD9  = 32'h008404B3;
    localparam logic [31:0] I_NOP   = 32'h00000000;
    localparam logic [31:0] I_ONES  = 32'h0000007F;

    logic               clk_i;
    logic               rst_i;
    logic [31:0]        instr_i;
    logic               flush_i;
    logic [ALUOP_W-1:0] ex_alu_op_o;
    logic               ex_alu_src_o;
    logic               ex_branch_o;
    logic [REG_W-1:0]   ex_rd_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic [REG_W-1:0]   mem_rd_o;
    logic               wb_reg_write_o;
    logic               wb_mem_to_reg_o;
    logic [REG_W-1:0]   wb_rd_o;
    logic               stall_o;

    pipe_ctrl #(
        .ALUOP_W(ALUOP_W),
        .MUL_LAT(MUL_LAT),
        .REG_W  (REG_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_i        (instr_i),
        .flush_i        (flush_i),
        .ex_alu_op_o    (ex_alu_op_o),
        .ex_alu_src_o   (ex_alu_src_o),
        .ex_branch_o    (ex_branch_o),
        .ex_rd_o        (ex_rd_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .mem_rd_o       (mem_rd_o),
        .wb_reg_write_o (wb_reg_write_o),
        .wb_mem_to_reg_o(wb_mem_to_reg_o),
        .wb_rd_o        (wb_rd_o),
        .stall_o        (stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int alu_op;
        bit alu_src;
        bit branch;
        bit mem_read;
        bit mem_write;
        bit reg_write;
        bit mem_to_reg;
        int rd;
        bit is_mul;
    } ctl_t;

    ctl_t m_ex, m_mem, m_wb;
    int   m_busy_left;
    bit   m_stall;
    int   n_checks;
    int   n_fail;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ctl_t bubble();
        ctl_t c;
        c.alu_op = 0; c.alu_src = 0; c.branch = 0; c.mem_read = 0;
        c.mem_write = 0; c.reg_write = 0; c.mem_to_reg = 0; c.rd = 0; c.is_mul = 0;
        return c;
    endfunction

    function automatic ctl_t decode(input logic [31:0] ins);
        ctl_t c;
        c = bubble();
        case (ins[6:0])
            7'h33: begin
                c.reg_write = 1; c.rd = int'(ins[11:7]);
                c.alu_op = ins[30] ? 2 : (ins[25] ? 3 : int'(ins[14:12]));
                c.is_mul = !ins[30] && ins[25];
            end
            7'h13: begin
                c.alu_src = 1; c.reg_write = 1; c.rd = int'(ins[11:7]);
                c.alu_op = int'(ins[14:12]);
            end
            7'h03: begin
                c.alu_src = 1; c.reg_write = 1; c.mem_read = 1; c.mem_to_reg = 1;
                c.rd = int'(ins[11:7]);
            end
            7'h23: begin c.alu_src = 1; c.mem_write = 1; end
            7'h63: begin c.branch = 1; c.alu_op = 2; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic bit model_lu(input logic [31:0] ins);
        bit uses_rs2;
        uses_rs2 = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
        return LU_EN && m_ex.mem_read && (m_ex.rd != 0) &&
               ((m_ex.rd == int'(ins[19:15])) || (uses_rs2 && m_ex.rd == int'(ins[24:20])));
    endfunction

    task automatic check_outputs();
        chk("ex_alu_op",   ex_alu_op_o,     m_ex.alu_op);
        chk("ex_alu_src",  ex_alu_src_o,    m_ex.alu_src);
        chk("ex_branch",   ex_branch_o,     m_ex.branch);
        chk("ex_rd",       ex_rd_o,         m_ex.rd);
        chk("mem_read",    mem_read_o,      m_mem.mem_read);
        chk("mem_write",   mem_write_o,     m_mem.mem_write);
        chk("mem_rd",      mem_rd_o,        m_mem.rd);
        chk("wb_reg_wr",   wb_reg_write_o,  m_wb.reg_write);
        chk("wb_mem2reg",  wb_mem_to_reg_o, m_wb.mem_to_reg);
        chk("wb_rd",       wb_rd_o,         m_wb.rd);
    endtask

    // One clock: drive ID, check stall, advance the model, then check registered outputs
    task automatic step(input logic [31:0] ins, input bit fl);
        instr_i = ins;
        flush_i = fl;
        #1;
        m_stall = (m_busy_left > 0) || model_lu(ins);
        chk("stall", stall_o, m_stall);
        m_wb = m_mem;
        if (m_busy_left > 0) begin
            if (m_busy_left == 1) begin
                m_mem = m_ex;
                m_ex  = bubble();
            end else begin
                m_mem = bubble();
            end
            m_busy_left--;
        end else begin
            m_mem = m_ex;
            if (m_stall || fl) begin
                m_ex = bubble();
            end else begin
                m_ex = decode(ins);
                if (m_ex.is_mul) m_busy_left = int'(MUL_LAT) - 1;
            end
        end
        @(posedge clk_i);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        chk("rst_outputs", int'({ex_alu_op_o, ex_alu_src_o, ex_branch_o, ex_rd_o, mem_read_o,
                                 mem_write_o, mem_rd_o, wb_reg_write_o, wb_mem_to_reg_o,
                                 wb_rd_o}), 0);
        chk("rst_stall", stall_o, 0);
        m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
        m_busy_left = 0;
        m_stall = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7, opc;
        logic [31:0] r;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        r   = $urandom;
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 9))
            0, 1:    opc = 7'h33;
            2:       opc = 7'h13;
            3, 4:    opc = 7'h03;
            5:       opc = 7'h23;
            6:       opc = 7'h63;
            7:       opc = 7'h7F;
            8:       opc = 7'h37;
            default: opc = 7'h00;
        endcase
        return {f7, rs2, rs1, f3, rd, opc} ^ ((opc == 7'h33) ? 32'h0 : {r[31:25], 25'h0});
    endfunction

    initial begin
        logic [31:0] ins;
        n_checks = 0;
        n_fail   = 0;
        rst_i    = 1'b0;
        instr_i  = I_NOP;
        flush_i  = 1'b0;
        m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
        m_busy_left = 0;
        #2;
        do_reset();

        // add x3,x1,x2: EX after 1 edge, WB after 3
        step(I_ADD3, 0);
        chk("add_ex_op", ex_alu_op_o, 0);
        chk("add_ex_rd", ex_rd_o, 3);
        step(I_NOP, 0);
        step(I_NOP, 0);
        chk("add_wb_we", wb_reg_write_o, 1);
        chk("add_wb_rd", wb_rd_o, 3);

        // mul x5,x6,x7: two stall cycles, MEM bubbles, then MUL in MEM
        step(I_MUL5, 0);
        chk("mul_ex_op", ex_alu_op_o, 3);
        chk("mul_stall1", stall_o, 1);
        chk("mul_mem_rd1", mem_rd_o, 0);
        step(I_NOP, 0);
        chk("mul_stall2", stall_o, 1);
        chk("mul_mem_rd2", mem_rd_o, 0);
        step(I_NOP, 0);
        chk("mul_stall_end", stall_o, 0);
        chk("mul_mem_rd", mem_rd_o, 5);

        // beq then flushed sub: EX gets a bubble
        step(I_BEQ, 0);
        chk("beq_branch", ex_branch_o, 1);
        chk("beq_op", ex_alu_op_o, 2);
        step(I_SUB4, 1);
        chk("flush_ex", int'({ex_alu_op_o, ex_alu_src_o, ex_branch_o, ex_rd_o}), 0);

        // lw x8 then add x9,x8,x8
        step(I_LW8, 0);
        instr_i = I_ADD9;
        #1;
        chk("lu_stall", stall_o, LU_EN ? 1 : 0);
        step(I_ADD9, 0);
        chk("lu_ex_rd1", ex_rd_o, LU_EN ? 0 : 9);
        step(LU_EN ? I_ADD9 : I_NOP, 0);
        chk("lu_ex_rd2", ex_rd_o, LU_EN ? 9 : 0);

        // Unknown opcodes decode as full bubbles with no stall
        step(I_ONES, 0);
        chk("op7f_ex", int'({ex_alu_op_o, ex_alu_src_o, ex_branch_o, ex_rd_o}), 0);
        chk("op7f_stall", stall_o, 0);
        step(I_NOP, 0);

        // Reset while a MUL is busy
        step(I_MUL5, 0);
        do_reset();
        step(I_NOP, 0);
        step(I_ADD3, 0);

        // Random streams; ID holds its instruction whenever the model says stall
        ins = rand_instr();
        for (int i = 0; i < 900; i++) begin
            if (i % 300 == 299) do_reset();
            step(ins, ($urandom_range(0, 9) == 0));
            if (!m_stall) ins = rand_instr();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
